// File: rtl/regfile_dump_ctrl_pkg.sv
// Shared debug definitions: dump FSM encoding, default geometry, bytes-per-word helper.
// Pure declarations; no logic or timing of its own.
package mips_debug_defs;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_READ    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_SEND    = 3'd4,
    ST_FINISH  = 3'd5
  } dump_state_t;

  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_DATA_W   = 32;

  localparam int DBG_BYTES_PER_WORD = DEF_DATA_W / 8;

  function automatic int dbg_bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/regfile_dump_ctrl_word_byte_serializer.sv
// Loads a word and emits it LSB byte first; TxValid rises the cycle after load.
// Holds valid and data steady until accepted; ready may stall forever.
module word_byte_serializer
  import mips_debug_defs::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              last_accept
);

  localparam int BYTES = dbg_bytes_per_word(DATA_W);
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  logic [BYTES-1:0][7:0] word_q;
  logic [IDX_W-1:0]      idx;

  assign tx_data     = word_q[idx];
  assign last_accept = tx_valid && tx_ready && (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q   <= '0;
      idx      <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      word_q   <= word;
      idx      <= '0;
      tx_valid <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      if (idx == LAST_IDX) begin
        tx_valid <= 1'b0;
        idx      <= '0;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/regfile_dump_ctrl.sv
// Stalls the pipeline, reads R0..R(NUM_REGS-1) over read port 1 and streams them as bytes.
// First byte 3 cycles after PipeIdle is seen; UART backpressure stalls the dump indefinitely.
module regfile_dump_ctrl
  import mips_debug_defs::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic              ClockIn,
  input  logic              Reset,
  input  logic              DumpReq,
  input  logic              PipeIdle,
  output logic              StallReq,
  output logic              DbgReadEn,
  output logic [ADDR_W-1:0] DbgReadAddr,
  input  logic [DATA_W-1:0] DbgReadData,
  output logic [7:0]        TxData,
  output logic              TxValid,
  input  logic              TxReady,
  output logic              Busy,
  output logic              Done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  dump_state_t state;
  logic        last_accept;
  logic        load_word;

  assign load_word = (state == ST_CAPTURE);

  word_byte_serializer #(
    .DATA_W(DATA_W)
  ) u_serializer (
    .clk        (ClockIn),
    .rst_n      (Reset),
    .load       (load_word),
    .word       (DbgReadData),
    .tx_data    (TxData),
    .tx_valid   (TxValid),
    .tx_ready   (TxReady),
    .last_accept(last_accept)
  );

  // DbgReadAddr doubles as the register counter; it never advances past LAST_ADDR.
  always_ff @(posedge ClockIn or negedge Reset) begin
    if (!Reset) begin
      state       <= ST_IDLE;
      StallReq    <= 1'b0;
      DbgReadEn   <= 1'b0;
      DbgReadAddr <= '0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (DumpReq) begin
            state    <= ST_DRAIN;
            StallReq <= 1'b1;
            Busy     <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (PipeIdle) begin
            state     <= ST_READ;
            DbgReadEn <= 1'b1;
          end
        end
        ST_READ:    state <= ST_CAPTURE;
        ST_CAPTURE: state <= ST_SEND;
        ST_SEND: begin
          if (last_accept) begin
            if (DbgReadAddr == LAST_ADDR) begin
              state       <= ST_FINISH;
              Done        <= 1'b1;
              StallReq    <= 1'b0;
              DbgReadEn   <= 1'b0;
              Busy        <= 1'b0;
              DbgReadAddr <= '0;
            end else begin
              state       <= ST_READ;
              DbgReadAddr <= DbgReadAddr + ADDR_W'(1);
            end
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default: begin
          state     <= ST_IDLE;
          StallReq  <= 1'b0;
          DbgReadEn <= 1'b0;
          Busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Directed bench: table of dump scenarios on a 32-register instance plus hand sequences
// for reset abort, ignored re-request, held request and a 3-register instance.
module tb_regfile_dump_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        dump_req, dump_req_b, pipe_idle, tx_ready;
  logic        stall_a, rden_a, txv_a, busy_a, done_a;
  logic [4:0]  addr_a;
  logic [31:0] rdata_a;
  logic [7:0]  txd_a;
  logic        stall_b, rden_b, txv_b, busy_b, done_b;
  logic [4:0]  addr_b;
  logic [31:0] rdata_b;
  logic [7:0]  txd_b;

  logic [31:0] regs [32];
  assign rdata_a = regs[addr_a];
  assign rdata_b = regs[addr_b];

  regfile_dump_ctrl dut_a (
    .ClockIn(clk), .Reset(rst_n), .DumpReq(dump_req), .PipeIdle(pipe_idle),
    .StallReq(stall_a), .DbgReadEn(rden_a), .DbgReadAddr(addr_a), .DbgReadData(rdata_a),
    .TxData(txd_a), .TxValid(txv_a), .TxReady(tx_ready), .Busy(busy_a), .Done(done_a)
  );

  regfile_dump_ctrl #(.NUM_REGS(3)) dut_b (
    .ClockIn(clk), .Reset(rst_n), .DumpReq(dump_req_b), .PipeIdle(pipe_idle),
    .StallReq(stall_b), .DbgReadEn(rden_b), .DbgReadAddr(addr_b), .DbgReadData(rdata_b),
    .TxData(txd_b), .TxValid(txv_b), .TxReady(tx_ready), .Busy(busy_b), .Done(done_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] base;
    int          idle_delay;
    int          ready_mode;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } scenario_t;

  logic [7:0] q_a [$];
  logic [7:0] q_b [$];
  logic [4:0] addr_log_b [$];
  int done_a_cnt, done_b_cnt, bytes_at_done_a, bytes_at_done_b, max_addr_b;
  logic       hold_a;
  logic [7:0] hold_dat_a;

  int ready_mode = 0;
  int hold_cnt   = 0;
  logic held     = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_a) begin
        check("tx_hold_valid", {31'd0, txv_a}, 32'd1);
        check("tx_hold_data", {24'd0, txd_a}, {24'd0, hold_dat_a});
      end
      if (txv_a && tx_ready) q_a.push_back(txd_a);
      if (txv_b && tx_ready) q_b.push_back(txd_b);
      if (done_a) begin done_a_cnt++; bytes_at_done_a = q_a.size(); end
      if (done_b) begin done_b_cnt++; bytes_at_done_b = q_b.size(); end
      if (rden_b) begin
        if (addr_log_b.size() == 0 || addr_log_b[$] != addr_b) addr_log_b.push_back(addr_b);
        if (int'(addr_b) > max_addr_b) max_addr_b = int'(addr_b);
      end
    end
    hold_a     = rst_n && txv_a && !tx_ready;
    hold_dat_a = txd_a;
  end

  // Ready pattern: 0 = always ready, 1 = random, 2 = random with a 20-cycle stall on R7 byte 3.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 0) tx_ready = 1'b1;
      else if (hold_cnt > 0) begin tx_ready = 1'b0; hold_cnt--; end
      else if (ready_mode == 2 && !held && txv_a && q_a.size() == 31) begin
        held = 1'b1; hold_cnt = 19; tx_ready = 1'b0;
      end else tx_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic preload(input logic [31:0] base);
    for (int n = 0; n < 32; n++) regs[n] = base + 32'(n);
  endtask

  task automatic clear_a();
    q_a.delete(); done_a_cnt = 0; bytes_at_done_a = 0;
  endtask

  task automatic wait_done_a(input int budget);
    int c = 0;
    while (done_a_cnt == 0 && c < budget) begin @(posedge clk); c++; end
    check("done_a_timeout", {31'd0, done_a_cnt != 0}, 32'd1);
  endtask

  task automatic pulse_req_a();
    @(posedge clk); #1 dump_req = 1'b1;
    @(posedge clk); #1 dump_req = 1'b0;
  endtask

  scenario_t sc [3];

  initial begin
    int lat, mism, c;
    sc[0] = '{32'hA0B0C000, 0,  0, 32'hA0B0C000, 32'hA0B0C01F};
    sc[1] = '{32'h5A5A0100, 10, 1, 32'h5A5A0100, 32'h5A5A011F};
    sc[2] = '{32'h00FF1200, 2,  2, 32'h00FF1200, 32'h00FF121F};

    rst_n = 1'b0; dump_req = 1'b0; dump_req_b = 1'b0; pipe_idle = 1'b0;
    preload(32'h0);
    max_addr_b = 0; done_b_cnt = 0; bytes_at_done_b = 0;
    clear_a();
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", {31'd0, stall_a}, 32'd0);
    check("rst_rden", {31'd0, rden_a}, 32'd0);
    check("rst_addr", {27'd0, addr_a}, 32'd0);
    check("rst_txv", {31'd0, txv_a}, 32'd0);
    check("rst_txd", {24'd0, txd_a}, 32'd0);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_done", {31'd0, done_a}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int s = 0; s < 3; s++) begin
      preload(sc[s].base);
      clear_a();
      ready_mode = sc[s].ready_mode;
      held = 1'b0;
      @(posedge clk); #1 dump_req = 1'b1; pipe_idle = (sc[s].idle_delay == 0);
      @(posedge clk); #1 dump_req = 1'b0;
      check("stall_on", {31'd0, stall_a}, 32'd1);
      check("busy_on", {31'd0, busy_a}, 32'd1);
      if (sc[s].idle_delay > 0) begin
        for (int i = 0; i < sc[s].idle_delay; i++) begin
          check("drain_stall", {31'd0, stall_a}, 32'd1);
          check("drain_rden", {31'd0, rden_a}, 32'd0);
          check("drain_txv", {31'd0, txv_a}, 32'd0);
          @(posedge clk); #1;
        end
        pipe_idle = 1'b1;
        lat = 0;
        while (!txv_a && lat < 20) begin @(posedge clk); #1; lat++; end
        check("first_byte_latency", 32'(lat), 32'd3);
      end
      wait_done_a(4000);
      repeat (3) @(posedge clk);
      #1;
      check("byte_count", 32'(q_a.size()), 32'd128);
      check("done_pulses", 32'(done_a_cnt), 32'd1);
      check("bytes_at_done", 32'(bytes_at_done_a), 32'd128);
      if (q_a.size() == 128) begin
        check("first_word", {q_a[3], q_a[2], q_a[1], q_a[0]}, sc[s].exp_first);
        check("last_word", {q_a[127], q_a[126], q_a[125], q_a[124]}, sc[s].exp_last);
        mism = 0;
        for (int n = 0; n < 32; n++)
          for (int b = 0; b < 4; b++)
            if (q_a[n*4+b] !== regs[n][8*b +: 8]) mism++;
        check("stream_bytes", 32'(mism), 32'd0);
      end
      check("stall_after", {31'd0, stall_a}, 32'd0);
      check("busy_after", {31'd0, busy_a}, 32'd0);
      check("rden_after", {31'd0, rden_a}, 32'd0);
    end

    // Reset lands while R5 byte 2 is on the wire.
    ready_mode = 0;
    preload(32'hA0B0C000);
    clear_a();
    pulse_req_a();
    c = 0;
    while (q_a.size() < 22 && c < 500) begin @(negedge clk); #1; c++; end
    check("reach_r5", 32'(q_a.size()), 32'd22);
    @(posedge clk); #1;
    check("mid_send_addr", {27'd0, addr_a}, 32'd5);
    check("mid_send_byte", {24'd0, txd_a}, 32'h000000B0);
    rst_n = 1'b0;
    #1;
    check("async_stall", {31'd0, stall_a}, 32'd0);
    check("async_txv", {31'd0, txv_a}, 32'd0);
    check("async_busy", {31'd0, busy_a}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_a();
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_bytes", 32'(q_a.size()), 32'd0);
    check("post_rst_busy", {31'd0, busy_a}, 32'd0);
    check("post_rst_stall", {31'd0, stall_a}, 32'd0);

    // Second request 40 cycles in is dropped.
    clear_a();
    pulse_req_a();
    repeat (38) @(posedge clk);
    #1 dump_req = 1'b1;
    check("busy_at_2nd_req", {31'd0, busy_a}, 32'd1);
    @(posedge clk); #1 dump_req = 1'b0;
    wait_done_a(4000);
    repeat (30) @(posedge clk);
    #1;
    check("ignored_req_bytes", 32'(q_a.size()), 32'd128);
    check("ignored_req_done", 32'(done_a_cnt), 32'd1);
    check("ignored_req_busy", {31'd0, busy_a}, 32'd0);

    // Three-register instance.
    q_b.delete(); addr_log_b.delete(); max_addr_b = 0; done_b_cnt = 0;
    @(posedge clk); #1 dump_req_b = 1'b1;
    @(posedge clk); #1 dump_req_b = 1'b0;
    c = 0;
    while (done_b_cnt == 0 && c < 500) begin @(posedge clk); c++; end
    repeat (3) @(posedge clk);
    #1;
    check("b_bytes", 32'(q_b.size()), 32'd12);
    check("b_bytes_at_done", 32'(bytes_at_done_b), 32'd12);
    check("b_done_pulses", 32'(done_b_cnt), 32'd1);
    check("b_addr_count", 32'(addr_log_b.size()), 32'd3);
    if (addr_log_b.size() == 3) begin
      check("b_addr0", {27'd0, addr_log_b[0]}, 32'd0);
      check("b_addr1", {27'd0, addr_log_b[1]}, 32'd1);
      check("b_addr2", {27'd0, addr_log_b[2]}, 32'd2);
    end
    check("b_no_addr3", {31'd0, max_addr_b <= 2}, 32'd1);
    if (q_b.size() == 12)
      check("b_last_word", {q_b[11], q_b[10], q_b[9], q_b[8]}, 32'hA0B0C002);

    // Request held through FINISH restarts on the following IDLE cycle.
    q_b.delete(); done_b_cnt = 0;
    @(posedge clk); #1 dump_req_b = 1'b1;
    c = 0;
    while (!done_b && c < 500) begin @(posedge clk); #1; c++; end
    check("held_finish_busy", {31'd0, busy_b}, 32'd0);
    @(posedge clk); #1;
    check("held_idle_busy", {31'd0, busy_b}, 32'd0);
    @(posedge clk); #1;
    check("held_restart_busy", {31'd0, busy_b}, 32'd1);
    check("held_restart_stall", {31'd0, stall_b}, 32'd1);
    dump_req_b = 1'b0;
    c = 0;
    while (done_b_cnt < 2 && c < 500) begin @(posedge clk); c++; end
    repeat (3) @(posedge clk);
    #1;
    check("held_total_bytes", 32'(q_b.size()), 32'd24);
    check("held_idle_after", {31'd0, busy_b}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
